// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial WIDTH-bit subtractor: diff = (a - b - bin) mod 2^WIDTH, computed
// LSB first through a 1-bit full-subtractor cell, one bit per clock.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous reset, active-high
//   start - request; honoured only in IDLE or DONE
//   a, b  - minuend / subtrahend, captured on an accepted start
//   bin   - borrow-in, captured on an accepted start (seeds the running borrow)
//   busy  - high while bits are being processed (state RUN)
//   done  - one-cycle pulse; diff/bout hold the new result from this cycle on
//   diff  - result, held until the next completion or reset
//   bout  - borrow-out, 1 iff a < b + bin (unsigned)
module serial_subtractor #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             bw_reg, bw_next;
    logic [WIDTH-1:0] a_sh_reg, a_sh_next;
    logic [WIDTH-1:0] b_sh_reg, b_sh_next;
    logic [WIDTH-1:0] res_sh_reg, res_sh_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             bout_reg, bout_next;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    logic bit_d;
    logic bit_bw;
    assign bit_d  = a_sh_reg[0] ^ b_sh_reg[0] ^ bw_reg;
    assign bit_bw = (~a_sh_reg[0] & b_sh_reg[0]) |
                    (~(a_sh_reg[0] ^ b_sh_reg[0]) & bw_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bw_next     = bw_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        res_sh_next = res_sh_reg;
        diff_next   = diff_reg;
        bout_next   = bout_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    bw_next    = bin;
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                // Result enters from the MSB side: after WIDTH shifts bit 0
                // has reached the LSB.
                res_sh_next = {bit_d, res_sh_reg[WIDTH-1:1]};
                a_sh_next   = a_sh_reg >> 1;
                b_sh_next   = b_sh_reg >> 1;
                bw_next     = bit_bw;
                if (cnt_reg == LAST_BIT) begin
                    diff_next  = res_sh_next;
                    bout_next  = bit_bw;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            bw_reg     <= 1'b0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            bw_reg     <= bw_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            res_sh_reg <= res_sh_next;
            diff_reg   <= diff_next;
            bout_reg   <= bout_next;
        end
    end

    // Outputs come straight from registers or registered-state decode.
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;

`ifdef FORMAL
    // Shadow copies of the operands, compared against the serial result.
    logic [WIDTH-1:0] a_cap_reg;
    logic [WIDTH-1:0] b_cap_reg;
    logic             bin_cap_reg;
    logic             done_d_reg;
    logic             restart_d_reg;
    logic             rst_d_reg;

    always_ff @(posedge clk) begin
        rst_d_reg     <= rst;
        done_d_reg    <= rst ? 1'b0 : done;
        restart_d_reg <= !rst && done && start;
        if (rst) begin
            a_cap_reg   <= '0;
            b_cap_reg   <= '0;
            bin_cap_reg <= 1'b0;
        end else if (start && state_reg != RUN) begin
            a_cap_reg   <= a;
            b_cap_reg   <= b;
            bin_cap_reg <= bin;
        end
    end

    always_comb begin
        assert (!(busy && done));
        if (done) begin
            assert (diff == a_cap_reg - b_cap_reg - WIDTH'(bin_cap_reg));
            assert (bout == ({1'b0, a_cap_reg} <
                             {1'b0, b_cap_reg} + (WIDTH + 1)'(bin_cap_reg)));
        end
        if (done_d_reg && done) begin
            assert (restart_d_reg);
        end
        if (rst_d_reg) begin
            assert (diff == '0 && bout == 1'b0);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: WIDTH=8 and WIDTH=2 instances checked
// against an arithmetic reference (a - b - bin, unsigned compare for borrow).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, done2, bout2;
    logic [1:0] a2, b2, diff2;

    int total = 0;
    int bad   = 0;

    logic [7:0] last_diff8 = 8'h00;
    logic       last_bout8 = 1'b0;
    logic [1:0] last_diff2 = 2'b00;
    logic       last_bout2 = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    // Starts an 8-bit operation at the current negedge and returns at the
    // negedge where done is observed (so a following call is back-to-back).
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        int  k;
        int  ed;
        int  eb;
        bit  seen;
        ed = (int'(av) - int'(bv) - int'(bi)) & 32'hFF;
        eb = (int'(av) < int'(bv) + int'(bi)) ? 1 : 0;
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        k = 1;
        seen = 0;
        while (!seen && k <= 12) begin
            total++;
            if (busy8 && done8) begin
                bad++;
                $display("FAIL overlap8 busy=%b done=%b required not both high", busy8, done8);
            end
            if (done8) begin
                seen = 1;
            end else begin
                total++;
                if (busy8 !== 1'b1 || diff8 !== last_diff8 || bout8 !== last_bout8) begin
                    bad++;
                    $display("FAIL run8 cycle %0d busy=%b diff=%h bout=%b required busy=1 diff=%h bout=%b",
                             k, busy8, diff8, bout8, last_diff8, last_bout8);
                end
                @(negedge clk);
                k++;
            end
        end
        total++;
        if (!seen || k != 9) begin
            bad++;
            $display("FAIL latency8 a=%h b=%h got=%0d (seen=%0d) required=9", av, bv, k, seen);
        end
        total++;
        if (diff8 !== ed[7:0] || bout8 !== eb[0]) begin
            bad++;
            $display("FAIL result8 a=%h b=%h bin=%b got diff=%h bout=%b required diff=%h bout=%b",
                     av, bv, bi, diff8, bout8, ed[7:0], eb[0]);
        end
        last_diff8 = ed[7:0];
        last_bout8 = eb[0];
    endtask

    task automatic do_op2(input logic [1:0] av, input logic [1:0] bv, input logic bi);
        int  k;
        int  ed;
        int  eb;
        bit  seen;
        ed = (int'(av) - int'(bv) - int'(bi)) & 32'h3;
        eb = (int'(av) < int'(bv) + int'(bi)) ? 1 : 0;
        a2 = av; b2 = bv; bin2 = bi; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        a2 = 2'($urandom); b2 = 2'($urandom); bin2 = 1'($urandom);
        k = 1;
        seen = 0;
        while (!seen && k <= 7) begin
            total++;
            if (busy2 && done2) begin
                bad++;
                $display("FAIL overlap2 busy=%b done=%b required not both high", busy2, done2);
            end
            if (done2) begin
                seen = 1;
            end else begin
                total++;
                if (busy2 !== 1'b1 || diff2 !== last_diff2 || bout2 !== last_bout2) begin
                    bad++;
                    $display("FAIL run2 cycle %0d busy=%b diff=%h bout=%b required busy=1 diff=%h bout=%b",
                             k, busy2, diff2, bout2, last_diff2, last_bout2);
                end
                @(negedge clk);
                k++;
            end
        end
        total++;
        if (!seen || k != 3) begin
            bad++;
            $display("FAIL latency2 a=%h b=%h got=%0d (seen=%0d) required=3", av, bv, k, seen);
        end
        total++;
        if (diff2 !== ed[1:0] || bout2 !== eb[0]) begin
            bad++;
            $display("FAIL result2 a=%h b=%h bin=%b got diff=%h bout=%b required diff=%h bout=%b",
                     av, bv, bi, diff2, bout2, ed[1:0], eb[0]);
        end
        last_diff2 = ed[1:0];
        last_bout2 = eb[0];
    endtask

    // Reset asserted together with start: reset must win.
    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0;
        start2 = 1'b1; a2 = 2'd3;  b2 = 2'd1;  bin2 = 1'b0;
        @(negedge clk);
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0) begin
            bad++;
            $display("FAIL reset8 busy=%b done=%b diff=%h bout=%b required 0 0 00 0",
                     busy8, done8, diff8, bout8);
        end
        total++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || diff2 !== 2'b00 || bout2 !== 1'b0) begin
            bad++;
            $display("FAIL reset2 busy=%b done=%b diff=%h bout=%b required 0 0 0 0",
                     busy2, done2, diff2, bout2);
        end
        rst = 1'b0; start8 = 1'b0; start2 = 1'b0;
        @(negedge clk);
        total++;
        if (busy8 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy8=%b busy2=%b required 0 0", busy8, busy2);
        end
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        do_op8(8'h05, 8'h03, 1'b0);
        @(negedge clk);
        do_op8(8'h03, 8'h05, 1'b0);
        @(negedge clk);
        do_op8(8'h00, 8'h00, 1'b1);
        @(negedge clk);
        $display("test_basic complete");
    endtask

    task automatic test_start_ignored();
        int ndone;
        int first;
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'hA5; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        ndone = 0;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            total++;
            if (busy8 && done8) begin
                bad++;
                $display("FAIL overlap_ign busy=%b done=%b required not both high", busy8, done8);
            end
            if (done8) begin
                ndone++;
                if (first == 0) first = k;
                total++;
                if (diff8 !== 8'h00 || bout8 !== 1'b0) begin
                    bad++;
                    $display("FAIL ignored_result diff=%h bout=%b required diff=00 bout=0", diff8, bout8);
                end
            end
            if (k == 3) begin
                start8 = 1'b1; a8 = 8'hFF;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (ndone != 1 || first != 9) begin
            bad++;
            $display("FAIL ignored_done count=%0d first=%0d required count=1 first=9", ndone, first);
        end
        last_diff8 = 8'h00;
        last_bout8 = 1'b0;
        $display("test_start_ignored complete");
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0) begin
            bad++;
            $display("FAIL abort busy=%b done=%b diff=%h bout=%b required 0 0 00 0",
                     busy8, done8, diff8, bout8);
        end
        last_diff8 = 8'h00; last_bout8 = 1'b0;
        last_diff2 = 2'b00; last_bout2 = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8 || busy8) ndone++;
            @(negedge clk);
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL abort_quiet active_cycles=%0d required=0", ndone);
        end
        do_op8(8'h80, 8'h01, 1'b0);
        @(negedge clk);
        $display("test_reset_mid_run complete");
    endtask

    task automatic test_back_to_back();
        do_op8(8'h10, 8'h01, 1'b0);
        do_op8(8'h00, 8'h01, 1'b0);
        @(negedge clk);
        $display("test_back_to_back complete");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            do_op8(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            do_op2(2'($urandom), 2'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
        $display("test_random complete");
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        test_reset();
        test_basic();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
